cofre_programavel: RTL and testbench

//  Parametrised successor of the 2-bit-digit safe lock. Compares a PASS_LEN-digit

---
 rtl/cofre_programavel.sv | 187 ++++++++++++++++++
 tb/tb_cofre_programavel.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cofre_programavel.sv
// Programmable digit-code safe lock.
// Compares a PASS_LEN-digit code, entered one digit per clock, against a stored
// password. The password can be reprogrammed while the safe is open, and
// MAX_TRIES consecutive wrong codes put the lock into a timed lockout.
//
// Handshake: there is no valid/ready pair. A keypad entry is any clock edge on
// which digito is non-zero. Every output is registered and reflects the state
// entered on the previous edge.
//
// "program" is a reserved word in SystemVerilog, so that request input is
// named program_i. state_o exposes the FSM state for debug.
module cofre_programavel #(
    parameter int                            DIGIT_W      = 2,
    parameter int                            PASS_LEN     = 5,
    parameter logic [PASS_LEN*DIGIT_W-1:0]   DEFAULT_PASS = 10'b11_10_01_10_11,
    parameter int                            MAX_TRIES    = 3,
    parameter int                            LOCK_CYCLES  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DIGIT_W-1:0]               digito,
    input  logic                             program_i,
    output logic                             led,
    output logic                             prog_led,
    output logic                             alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
    output logic [1:0]                       state_o
);

    localparam int IDX_W   = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = $clog2(LOCK_CYCLES + 1);
    localparam int PW      = PASS_LEN * DIGIT_W;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PASS_LEN - 1);
    localparam logic [TRIES_W-1:0] MAX_T    = TRIES_W'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] LOCK_T   = TIMER_W'(LOCK_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_1  = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_ENTRY  = 2'd0,
        S_OPEN   = 2'd1,
        S_PROG   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t               state_q,    state_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic                 mismatch_q, mismatch_d;
    logic [TRIES_W-1:0]   tries_q,    tries_d;
    logic [TIMER_W-1:0]   timer_q,    timer_d;
    logic [PW-1:0]        pass_q,     pass_d;
    logic [PW-1:0]        shadow_q,   shadow_d;
    logic                 led_q, prog_led_q, alarm_q;

    logic [DIGIT_W-1:0]   slot_digit;
    logic                 digit_vld;
    logic                 is_last;
    logic                 miss;

    // Select the stored password digit at position idx (slot 0 sits in the MSBs).
    always_comb begin
        slot_digit = '0;
        for (int s = 0; s < PASS_LEN; s++) begin
            if (idx_q == IDX_W'(s)) begin
                slot_digit = pass_q[(PASS_LEN-1-s)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Next-state logic for the lock FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        tries_d    = tries_q;
        timer_d    = timer_q;
        pass_d     = pass_q;
        shadow_d   = shadow_q;
        miss       = 1'b0;
        digit_vld  = (digito != '0);
        is_last    = (idx_q == LAST_IDX);

        unique case (state_q)
            S_ENTRY: begin
                if (digit_vld) begin
                    // A wrong digit anywhere poisons the whole code; keep collecting.
                    miss = mismatch_q | (digito != slot_digit);
                    if (is_last) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!miss) begin
                            state_d = S_OPEN;
                            tries_d = '0;
                        end else if ((int'(tries_q) + 1) < MAX_TRIES) begin
                            tries_d = tries_q + 1'b1;
                        end else begin
                            state_d = S_LOCKED;
                            tries_d = MAX_T;
                            timer_d = LOCK_T;
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mismatch_d = miss;
                    end
                end
            end

            S_OPEN: begin
                // Program request wins; otherwise any key relocks and is dropped.
                if (program_i) begin
                    state_d = S_PROG;
                    idx_d   = '0;
                end else if (digit_vld) begin
                    state_d = S_ENTRY;
                end
            end

            S_PROG: begin
                if (digit_vld) begin
                    for (int s = 0; s < PASS_LEN; s++) begin
                        if (idx_q == IDX_W'(s)) begin
                            shadow_d[(PASS_LEN-1-s)*DIGIT_W +: DIGIT_W] = digito;
                        end
                    end
                    if (is_last) begin
                        // shadow_d already holds the final digit, so commit it directly.
                        pass_d  = shadow_d;
                        idx_d   = '0;
                        state_d = S_ENTRY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_LOCKED: begin
                // Inputs are ignored; leave on the edge that sees the last count.
                if (timer_q == TIMER_1) begin
                    state_d = S_ENTRY;
                    tries_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = S_ENTRY;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ENTRY;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            tries_q    <= '0;
            timer_q    <= '0;
            pass_q     <= DEFAULT_PASS;
            shadow_q   <= '0;
            led_q      <= 1'b0;
            prog_led_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            pass_q     <= pass_d;
            shadow_q   <= shadow_d;
            led_q      <= (state_d == S_OPEN);
            prog_led_q <= (state_d == S_PROG);
            alarm_q    <= (state_d == S_LOCKED);
        end
    end

    assign led      = led_q;
    assign prog_led = prog_led_q;
    assign alarm    = alarm_q;
    assign tries    = tries_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_cofre_programavel.sv
// Bench for cofre_programavel: directed keypad sequences, expectations queued
// by the driver and checked by an independent monitor.
module tb_cofre_programavel;

  localparam int W = 5;  // {led, prog_led, alarm, tries[1:0]}

  localparam logic [1:0] A = 2'd1;
  localparam logic [1:0] B = 2'd2;
  localparam logic [1:0] C = 2'd3;

  localparam logic [9:0] CODE_DEF = 10'b11_10_01_10_11;  // C,B,A,B,C
  localparam logic [9:0] CODE_W1  = 10'b11_01_01_11_10;  // C,A,A,C,B
  localparam logic [9:0] CODE_W2  = 10'b01_10_01_10_11;  // A,B,A,B,C (first digit wrong)
  localparam logic [9:0] CODE_W3  = 10'b11_10_01_10_10;  // C,B,A,B,B (last digit wrong)
  localparam logic [9:0] CODE_NEW = 10'b01_01_10_10_11;  // A,A,B,B,C

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] digito = 2'd0;
  logic       program_i = 1'b0;
  logic       led, prog_led, alarm;
  logic [1:0] tries;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  cofre_programavel dut (
    .clk       (clk),
    .reset     (reset),
    .digito    (digito),
    .program_i (program_i),
    .led       (led),
    .prog_led  (prog_led),
    .alarm     (alarm),
    .tries     (tries),
    .state_o   (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  event         sample_ev;

  function automatic logic [W-1:0] ex(bit l, bit p, bit a, int t);
    return {l, p, a, 2'(t)};
  endfunction

  task automatic expect_out(string nm, logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are stable at the falling edge (or on demand for async reset).
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        nm;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {led, prog_led, alarm, tries};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: actual led=%b prog_led=%b alarm=%b tries=%0d, required led=%b prog_led=%b alarm=%b tries=%0d",
                   nm, act[4], act[3], act[2], act[1:0], e[4], e[3], e[2], e[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock of stimulus; the expectation is for the outputs after that edge.
  task automatic drive(logic [1:0] d, logic p, string nm, logic [W-1:0] e);
    digito    = d;
    program_i = p;
    @(posedge clk);
    #1;
    digito    = 2'd0;
    program_i = 1'b0;
    expect_out(nm, e);
  endtask

  task automatic enter5(string nm, logic [9:0] code, logic p,
                        logic [W-1:0] mid, logic [W-1:0] fin);
    logic [9:0] c;
    c = code;
    for (int i = 0; i < 5; i++) begin
      drive(c[9-2*i -: 2], p, nm, (i == 4) ? fin : mid);
    end
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives.
  task automatic pulse_reset(string nm);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    digito    = 2'd0;
    program_i = 1'b0;
    #1;
    expect_out(nm, ex(0, 0, 0, 0));
    ->sample_ev;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pulse_reset("reset_initial");

    // Default code with nulls interleaved; led rises right after the last C.
    drive(C,    1'b0, "t1_d0",    ex(0, 0, 0, 0));
    drive(2'd0, 1'b0, "t1_null0", ex(0, 0, 0, 0));
    drive(B,    1'b0, "t1_d1",    ex(0, 0, 0, 0));
    drive(A,    1'b0, "t1_d2",    ex(0, 0, 0, 0));
    drive(2'd0, 1'b0, "t1_null1", ex(0, 0, 0, 0));
    drive(B,    1'b0, "t1_d3",    ex(0, 0, 0, 0));
    drive(C,    1'b0, "t1_open",  ex(1, 0, 0, 0));
    drive(2'd0, 1'b0, "t1_hold",  ex(1, 0, 0, 0));

    // Relock by a single key; that key must not count as the first digit.
    drive(B, 1'b0, "t5_relock", ex(0, 0, 0, 0));
    enter5("t5_open", CODE_DEF, 1'b0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));

    // One wrong code (repeated digits), then the right one clears tries.
    drive(A, 1'b0, "t2_relock", ex(0, 0, 0, 0));
    enter5("t2_wrong", CODE_W1,  1'b0, ex(0, 0, 0, 0), ex(0, 0, 0, 1));
    enter5("t2_right", CODE_DEF, 1'b0, ex(0, 0, 0, 1), ex(1, 0, 0, 0));

    // Three wrong codes -> lockout of 16 cycles; inputs ignored meanwhile.
    drive(A, 1'b0, "t3_relock", ex(0, 0, 0, 0));
    enter5("t3_w1", CODE_W2, 1'b0, ex(0, 0, 0, 0), ex(0, 0, 0, 1));
    enter5("t3_w2", CODE_W3, 1'b0, ex(0, 0, 0, 1), ex(0, 0, 0, 2));
    enter5("t3_w3", CODE_W1, 1'b0, ex(0, 0, 0, 2), ex(0, 0, 1, 3));
    enter5("t3_code_locked", CODE_DEF, 1'b0, ex(0, 0, 1, 3), ex(0, 0, 1, 3));
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 1) ? C : 2'd0, (i == 3) ? 1'b1 : 1'b0, "t3_locked", ex(0, 0, 1, 3));
    end
    drive(2'd0, 1'b0, "t3_release", ex(0, 0, 0, 0));
    enter5("t3_open", CODE_DEF, 1'b0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));

    // Reprogram to A,A,B,B,C; program held high during PROG is ignored.
    drive(C, 1'b1, "t4_prog", ex(0, 1, 0, 0));
    enter5("t4_capture", CODE_NEW, 1'b1, ex(0, 1, 0, 0), ex(0, 0, 0, 0));
    enter5("t4_old",     CODE_DEF, 1'b0, ex(0, 0, 0, 0), ex(0, 0, 0, 1));
    enter5("t4_new",     CODE_NEW, 1'b0, ex(0, 0, 0, 1), ex(1, 0, 0, 0));

    // Reset mid-entry restores the default password.
    drive(A, 1'b0, "t6_relock", ex(0, 0, 0, 0));
    drive(C, 1'b0, "t6_d0", ex(0, 0, 0, 0));
    drive(B, 1'b0, "t6_d1", ex(0, 0, 0, 0));
    drive(A, 1'b0, "t6_d2", ex(0, 0, 0, 0));
    pulse_reset("t6_reset_entry");
    enter5("t6_default", CODE_DEF, 1'b0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));

    // Reset while open, and reset during a partial reprogram.
    pulse_reset("t6_reset_open");
    enter5("t6_reopen", CODE_DEF, 1'b0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));
    drive(2'd0, 1'b1, "t6_prog", ex(0, 1, 0, 0));
    drive(A,    1'b0, "t6_p0",   ex(0, 1, 0, 0));
    drive(B,    1'b0, "t6_p1",   ex(0, 1, 0, 0));
    pulse_reset("t6_reset_prog");
    enter5("t6_final", CODE_DEF, 1'b0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));

    // ---------------- final report ----------------
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
